// File: rtl/lane_scrambler_if.sv
// Symbol stream between the scheduler mux and the lane scrambler, including the
// registered scrambler outputs toward the lane encoder.
interface lane_scrambler_if;
  logic       scramble_en;
  logic [7:0] in_symbol;
  logic       in_control_sym_flag;
  logic       in_valid;
  logic [7:0] out_symbol;
  logic       out_control_sym_flag;
  logic       out_valid;
  logic       sr_inserted;

  modport master (
    output scramble_en, in_symbol, in_control_sym_flag, in_valid,
    input  out_symbol, out_control_sym_flag, out_valid, sr_inserted
  );

  modport slave (
    input  scramble_en, in_symbol, in_control_sym_flag, in_valid,
    output out_symbol, out_control_sym_flag, out_valid, sr_inserted
  );
endinterface

// File: rtl/lane_scrambler.sv
// Per-lane DisplayPort main-link scrambler: 16-bit LFSR on data symbols, control
// symbols passed through, every SR_INTERVAL-th BS replaced by SR with an LFSR reseed.
module lane_scrambler #(
  parameter int unsigned SR_INTERVAL = 512,
  parameter logic [15:0] LFSR_SEED   = 16'hFFFF
) (
  input logic             clk,
  input logic             rst,
  lane_scrambler_if.slave bus
);
  localparam int unsigned    CW       = $clog2(SR_INTERVAL);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SR_INTERVAL - 1);
  localparam logic [7:0]     SYM_BS   = 8'hBC;
  localparam logic [7:0]     SYM_SR   = 8'h1C;
  localparam logic [15:0]    POLY     = 16'h0039;

  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [7:0]    scr;
  logic [CW-1:0] bs_cnt;
  logic          is_bs;
  logic          sr_hit;

  // Eight serial LFSR steps unrolled into one cycle, LSB of the symbol first.
  always_comb begin
    lfsr_next = lfsr;
    scr       = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      scr[i]    = bus.in_symbol[i] ^ lfsr_next[15];
      lfsr_next = {lfsr_next[14:0], 1'b0} ^ (lfsr_next[15] ? POLY : 16'h0000);
    end
  end

  assign is_bs  = bus.in_control_sym_flag && (bus.in_symbol == SYM_BS);
  assign sr_hit = is_bs && (bs_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_symbol           <= '0;
      bus.out_control_sym_flag <= 1'b0;
      bus.out_valid            <= 1'b0;
      bus.sr_inserted          <= 1'b0;
      lfsr                     <= LFSR_SEED;
      bs_cnt                   <= CNT_LAST;
    end else begin
      bus.out_valid   <= bus.in_valid;
      bus.sr_inserted <= 1'b0;
      if (!bus.scramble_en) begin
        // Bypass re-arms the seed and the SR counter regardless of in_valid.
        lfsr                     <= LFSR_SEED;
        bs_cnt                   <= CNT_LAST;
        bus.out_symbol           <= bus.in_valid ? bus.in_symbol : '0;
        bus.out_control_sym_flag <= bus.in_valid & bus.in_control_sym_flag;
      end else if (!bus.in_valid) begin
        bus.out_symbol           <= '0;
        bus.out_control_sym_flag <= 1'b0;
      end else if (sr_hit) begin
        bus.out_symbol           <= SYM_SR;
        bus.out_control_sym_flag <= 1'b1;
        bus.sr_inserted          <= 1'b1;
        lfsr                     <= LFSR_SEED;
        bs_cnt                   <= '0;
      end else begin
        lfsr                     <= lfsr_next;
        bus.out_symbol           <= bus.in_control_sym_flag ? bus.in_symbol : scr;
        bus.out_control_sym_flag <= bus.in_control_sym_flag;
        if (is_bs) begin
          bs_cnt <= bs_cnt + 1'b1;
        end
      end
    end
  end
endmodule
